// File: rtl/unet_patch_scheduler_if.sv
// Signal bundle between the patch scheduler and the wrapper around it:
// the U-Net handshake, the base-address BRAM port, the AXI master
// trigger, and the status outputs read by the water-S logic.
interface unet_patch_scheduler_if #(
  parameter int PATCH_W = 1
);
  logic               U_L0_Finish;
  logic               UW_busy;
  logic [31:0]        ram_addr;
  logic               ram_en;
  logic [31:0]        ram_rd_data;
  logic [31:0]        map_ptr;
  logic               txn_start;
  logic               txn_done;
  logic               txn_error;
  logic               UW_ready;
  logic               UW_Busy_for_WS;
  logic               UW_module_Finish;
  logic [PATCH_W-1:0] patch_num;
  logic [1:0]         err_flag;

  // Scheduler side.
  modport master (
    input  U_L0_Finish, UW_busy, ram_rd_data, txn_done, txn_error,
    output ram_addr, ram_en, map_ptr, txn_start, UW_ready, UW_Busy_for_WS,
           UW_module_Finish, patch_num, err_flag
  );

  // Wrapper / environment side.
  modport slave (
    output U_L0_Finish, UW_busy, ram_rd_data, txn_done, txn_error,
    input  ram_addr, ram_en, map_ptr, txn_start, UW_ready, UW_Busy_for_WS,
           UW_module_Finish, patch_num, err_flag
  );
endinterface

// File: rtl/unet_patch_scheduler.sv
// Flash write-back sequencer for U-Net output patches. Each layer-0
// completion walks that patch's mapping pointers in the base-address BRAM,
// hands each pointer to the CWBP decoder and fires one AXI master
// transaction per mapped pointer. Unmapped pointers are skipped. The last
// patch of a run raises a one-cycle module-finish pulse.
module unet_patch_scheduler #(
  parameter logic [31:0] BRAM_BASE_ADDR = 32'h4580_0000,
  parameter int          PTRS_PER_PATCH = 4,
  parameter int          PATCH_W        = 1,
  parameter logic [31:0] UNMAPPED_PTR   = 32'hFFFF_FFFF
) (
  input  logic                   m01_axi_aclk,
  input  logic                   m01_axi_aresetn,
  unet_patch_scheduler_if.master bus
);

  localparam int IDX_W = (PTRS_PER_PATCH > 1) ? $clog2(PTRS_PER_PATCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_ISSUE, S_WAIT, S_NEXT, S_ERR
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr_idx;
  logic [PATCH_W-1:0] patch_num;
  logic [31:0]        map_ptr;
  logic [1:0]         err_flag;
  logic [31:0]        word_idx;
  logic               last_ptr;
  logic               last_patch;

  logic [31:0]        ram_addr;
  logic               ram_en;
  logic               txn_start;
  logic               uw_ready;
  logic               uw_busy_ws;
  logic               module_finish;

  assign last_ptr   = (ptr_idx == IDX_W'(PTRS_PER_PATCH - 1));
  assign last_patch = &patch_num;
  // Word offset of the current pointer; 32-bit arithmetic wraps naturally.
  assign word_idx   = 32'(patch_num) * 32'(PTRS_PER_PATCH) + 32'(ptr_idx);

  // State register.
  always_ff @(posedge m01_axi_aclk or negedge m01_axi_aresetn) begin
    // NOTE: clocked state always uses non-blocking assignment so every
    // register samples the pre-edge values, independent of block order.
    if (!m01_axi_aresetn) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt
    // unassigned and infers a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.U_L0_Finish) state_nxt = S_RD;
      S_RD:    state_nxt = S_CAP;
      S_CAP:   state_nxt = (bus.ram_rd_data == UNMAPPED_PTR) ? S_NEXT : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (bus.txn_done) state_nxt = bus.txn_error ? S_ERR : S_NEXT;
      S_NEXT:  state_nxt = last_ptr ? S_IDLE : S_RD;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state and pointer/patch counters.
  always_comb begin
    ram_addr      = BRAM_BASE_ADDR + {word_idx[29:0], 2'b00};
    ram_en        = (state == S_RD);
    txn_start     = (state == S_ISSUE);
    uw_ready      = (state == S_IDLE) && !bus.UW_busy;
    uw_busy_ws    = (state != S_IDLE);
    module_finish = (state == S_NEXT) && last_ptr && last_patch;
  end

  // Pointer index, patch counter, captured pointer and sticky error bits.
  always_ff @(posedge m01_axi_aclk or negedge m01_axi_aresetn) begin
    if (!m01_axi_aresetn) begin
      ptr_idx   <= '0;
      patch_num <= '0;
      map_ptr   <= '0;
      err_flag  <= 2'b00;
    end else begin
      unique case (state)
        S_IDLE:  ptr_idx <= '0;
        S_CAP:   map_ptr <= bus.ram_rd_data;
        S_NEXT:  if (last_ptr) patch_num <= patch_num + 1'b1;
                 else          ptr_idx   <= ptr_idx + 1'b1;
        default: ;
      endcase
      if (state == S_WAIT && bus.txn_done && bus.txn_error) err_flag[0] <= 1'b1;
      // A new patch arriving while one is in flight is only flagged.
      if (state != S_IDLE && bus.U_L0_Finish)               err_flag[1] <= 1'b1;
    end
  end

  assign bus.ram_addr         = ram_addr;
  assign bus.ram_en           = ram_en;
  assign bus.map_ptr          = map_ptr;
  assign bus.txn_start        = txn_start;
  assign bus.UW_ready         = uw_ready;
  assign bus.UW_Busy_for_WS   = uw_busy_ws;
  assign bus.UW_module_Finish = module_finish;
  assign bus.patch_num        = patch_num;
  assign bus.err_flag         = err_flag;

endmodule

// File: tb/tb_unet_patch_scheduler.sv
// Bench for unet_patch_scheduler: BRAM model with one-cycle read latency,
// AXI stub answering 3 cycles after each start, negedge monitor, and a
// patch-level reference model of reads and transactions.
module tb_unet_patch_scheduler;
  localparam logic [31:0] BASE = 32'h4580_0000;
  localparam int          PTRS = 4;
  localparam int          PW   = 1;
  localparam logic [31:0] UNM  = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unet_patch_scheduler_if #(.PATCH_W(PW)) ifc ();

  unet_patch_scheduler #(
    .BRAM_BASE_ADDR(BASE), .PTRS_PER_PATCH(PTRS), .PATCH_W(PW), .UNMAPPED_PTR(UNM)
  ) dut (
    .m01_axi_aclk(clk), .m01_axi_aresetn(rst_n), .bus(ifc.master)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, t0 = 0, fin_n = 0, mdl_patch = 0;
  logic [31:0] rd_q[$], st_q[$], wp_q[$];
  int          st_cyc_q[$];
  logic [31:0] vals [PTRS];

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM: data appears the cycle after ram_en.
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk)
    if (ifc.ram_en) ifc.ram_rd_data <= mem.exists(ifc.ram_addr) ? mem[ifc.ram_addr] : 32'hDEAD_BEEF;

  // AXI stub: done 3 cycles after start; error on a chosen transaction;
  // optional stray txn_error noise when no done is present.
  logic [2:0] done_sr = '0, err_sr = '0;
  int start_cnt = 0, err_on = 0;
  bit noise = 0;
  logic noise_bit = 1'b0;
  always @(posedge clk) begin
    done_sr   <= {done_sr[1:0], ifc.txn_start};
    err_sr    <= {err_sr[1:0], ifc.txn_start && (start_cnt + 1 == err_on)};
    if (ifc.txn_start) start_cnt <= start_cnt + 1;
    noise_bit <= noise && ($urandom_range(0, 3) == 0);
  end
  assign ifc.txn_done  = done_sr[2];
  assign ifc.txn_error = done_sr[2] ? err_sr[2] : noise_bit;

  // Monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (ifc.ram_en) rd_q.push_back(ifc.ram_addr);
    if (ifc.txn_start) begin st_q.push_back(ifc.map_ptr); st_cyc_q.push_back(cyc); end
    if (ifc.txn_done && ifc.UW_Busy_for_WS) wp_q.push_back(ifc.map_ptr);
    if (ifc.UW_module_Finish) fin_n++;
  end

  function automatic logic [135:0] pack4(input logic [31:0] q[$]);
    logic [135:0] r = '0;
    r[135:128] = 8'(q.size());
    for (int i = 0; i < 4 && i < q.size(); i++) r[32*i +: 32] = q[i];
    return r;
  endfunction

  // Reference: a patch reads all its pointers in order and issues one
  // transaction per mapped pointer; the patch counter wraps at 2**PW.
  task automatic model(output logic [135:0] e_rd, output logic [135:0] e_txn,
                       output logic [PW-1:0] e_pn, output int e_fin);
    logic [31:0] rq[$], tq[$];
    for (int i = 0; i < PTRS; i++) begin
      rq.push_back(BASE + 32'(4 * (mdl_patch * PTRS + i)));
      if (vals[i] !== UNM) tq.push_back(vals[i]);
    end
    e_rd  = pack4(rq);
    e_txn = pack4(tq);
    e_pn  = PW'((mdl_patch + 1) % (2 ** PW));
    e_fin = (mdl_patch == 2 ** PW - 1) ? 1 : 0;
  endtask

  task automatic clear_mon();
    @(posedge clk); #1;
    rd_q.delete(); st_q.delete(); wp_q.delete(); st_cyc_q.delete(); fin_n = 0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < PTRS; i++) mem[BASE + 32'(4 * (mdl_patch * PTRS + i))] = vals[i];
  endtask

  task automatic pulse_finish();
    @(posedge clk); #1; ifc.U_L0_Finish = 1'b1; t0 = cyc;
    @(posedge clk); #1; ifc.U_L0_Finish = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!ifc.UW_Busy_for_WS) done = 1;
    end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL %s timeout: busy=%b after 300 cycles, want 0", name, ifc.UW_Busy_for_WS); end
  endtask

  task automatic do_patch(input string name);
    clear_mon();
    load_mem();
    pulse_finish();
    wait_idle(name);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [74:0] got, want;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got  = {ifc.ram_addr, ifc.ram_en, ifc.map_ptr, ifc.txn_start, ifc.UW_Busy_for_WS,
            ifc.UW_module_Finish, ifc.patch_num, ifc.err_flag, ifc.UW_ready};
    want = {BASE, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    n_cmp++; if (got !== want) begin n_bad++; $display("FAIL reset values: got %h want %h", got, want); end
    ifc.UW_busy = 1'b1; #1;
    n_cmp++; if (ifc.UW_ready !== 1'b0) begin n_bad++; $display("FAIL reset ready busy: got %b want 0", ifc.UW_ready); end
    ifc.UW_busy = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    clear_mon();
    repeat (20) @(negedge clk);
    n_cmp++; if (rd_q.size() != 0 || st_q.size() != 0) begin
      n_bad++; $display("FAIL reset quiet: reads=%0d starts=%0d want 0/0", rd_q.size(), st_q.size());
    end
  endtask

  task automatic test_patch0();
    logic [135:0] e_rd, e_txn; logic [PW-1:0] e_pn; int e_fin;
    vals = '{32'h0000_1003, 32'h0001_2000, 32'h0002_0001, 32'h0003_0004};
    model(e_rd, e_txn, e_pn, e_fin);
    do_patch("patch0");
    mdl_patch = (mdl_patch + 1) % (2 ** PW);
    n_cmp++; if (pack4(rd_q) !== e_rd)  begin n_bad++; $display("FAIL patch0 reads: got %h want %h", pack4(rd_q), e_rd); end
    n_cmp++; if (pack4(st_q) !== e_txn) begin n_bad++; $display("FAIL patch0 issue ptrs: got %h want %h", pack4(st_q), e_txn); end
    n_cmp++; if (pack4(wp_q) !== e_txn) begin n_bad++; $display("FAIL patch0 wait ptrs: got %h want %h", pack4(wp_q), e_txn); end
    n_cmp++; if (ifc.patch_num !== e_pn) begin n_bad++; $display("FAIL patch0 patch_num: got %0d want %0d", ifc.patch_num, e_pn); end
    n_cmp++; if (fin_n != e_fin) begin n_bad++; $display("FAIL patch0 finish: got %0d want %0d", fin_n, e_fin); end
    n_cmp++; if (st_cyc_q.size() == 0 || st_cyc_q[0] - t0 != 3) begin
      n_bad++; $display("FAIL patch0 latency: got %0d want 3", st_cyc_q.size() ? st_cyc_q[0] - t0 : -1);
    end
    n_cmp++; if (ifc.UW_ready !== 1'b1) begin n_bad++; $display("FAIL patch0 ready: got %b want 1", ifc.UW_ready); end
  endtask

  task automatic test_patch1();
    logic [135:0] e_rd, e_txn; logic [PW-1:0] e_pn; int e_fin;
    for (int i = 0; i < PTRS; i++) vals[i] = $urandom & 32'h7FFF_FFFF;
    model(e_rd, e_txn, e_pn, e_fin);
    do_patch("patch1");
    mdl_patch = (mdl_patch + 1) % (2 ** PW);
    n_cmp++; if (pack4(rd_q) !== e_rd)  begin n_bad++; $display("FAIL patch1 reads: got %h want %h", pack4(rd_q), e_rd); end
    n_cmp++; if (pack4(wp_q) !== e_txn) begin n_bad++; $display("FAIL patch1 wait ptrs: got %h want %h", pack4(wp_q), e_txn); end
    n_cmp++; if (ifc.patch_num !== e_pn) begin n_bad++; $display("FAIL patch1 patch_num: got %0d want %0d", ifc.patch_num, e_pn); end
    n_cmp++; if (fin_n != e_fin) begin n_bad++; $display("FAIL patch1 finish: got %0d want %0d", fin_n, e_fin); end
  endtask

  task automatic test_unmapped();
    logic [135:0] e_rd, e_txn; logic [PW-1:0] e_pn; int e_fin;
    for (int i = 0; i < PTRS; i++) vals[i] = $urandom & 32'h7FFF_FFFF;
    vals[2] = UNM;
    model(e_rd, e_txn, e_pn, e_fin);
    do_patch("unmapped");
    mdl_patch = (mdl_patch + 1) % (2 ** PW);
    n_cmp++; if (pack4(st_q) !== e_txn) begin n_bad++; $display("FAIL unmapped issues: got %h want %h", pack4(st_q), e_txn); end
    n_cmp++; if (ifc.patch_num !== e_pn) begin n_bad++; $display("FAIL unmapped patch_num: got %0d want %0d", ifc.patch_num, e_pn); end
    for (int i = 0; i < PTRS; i++) vals[i] = UNM;
    model(e_rd, e_txn, e_pn, e_fin);
    do_patch("all_unmapped");
    mdl_patch = (mdl_patch + 1) % (2 ** PW);
    n_cmp++; if (pack4(rd_q) !== e_rd || st_q.size() != 0) begin
      n_bad++; $display("FAIL all_unmapped: reads %h want %h, starts %0d want 0", pack4(rd_q), e_rd, st_q.size());
    end
    n_cmp++; if (ifc.patch_num !== e_pn || fin_n != e_fin) begin
      n_bad++; $display("FAIL all_unmapped advance: pn %0d/%0d fin %0d/%0d", ifc.patch_num, e_pn, fin_n, e_fin);
    end
  endtask

  task automatic test_random();
    logic [135:0] e_rd, e_txn; logic [PW-1:0] e_pn; int e_fin;
    noise = 1;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < PTRS; i++)
        vals[i] = ($urandom_range(0, 2) == 0) ? UNM : ($urandom & 32'h7FFF_FFFF);
      ifc.UW_busy = 1'($urandom_range(0, 1));
      model(e_rd, e_txn, e_pn, e_fin);
      do_patch("random");
      mdl_patch = (mdl_patch + 1) % (2 ** PW);
      n_cmp++; if (pack4(rd_q) !== e_rd || pack4(st_q) !== e_txn) begin
        n_bad++; $display("FAIL random[%0d] reads %h want %h, issues %h want %h", it, pack4(rd_q), e_rd, pack4(st_q), e_txn);
      end
      n_cmp++; if (ifc.patch_num !== e_pn || fin_n != e_fin) begin
        n_bad++; $display("FAIL random[%0d] pn %0d want %0d, fin %0d want %0d", it, ifc.patch_num, e_pn, fin_n, e_fin);
      end
      n_cmp++; if (ifc.UW_ready !== !ifc.UW_busy || ifc.err_flag !== 2'b00) begin
        n_bad++; $display("FAIL random[%0d] ready %b want %b, err %b want 00", it, ifc.UW_ready, !ifc.UW_busy, ifc.err_flag);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    noise = 0;
    ifc.UW_busy = 1'b0;
  endtask

  task automatic test_txn_error();
    for (int i = 0; i < PTRS; i++) vals[i] = $urandom & 32'h7FFF_FFFF;
    err_on = start_cnt + 2;
    clear_mon();
    load_mem();
    pulse_finish();
    repeat (40) @(negedge clk);
    n_cmp++; if ({ifc.err_flag, ifc.UW_ready, ifc.UW_Busy_for_WS} !== 4'b01_0_1) begin
      n_bad++; $display("FAIL error state: err=%b ready=%b busy=%b want 01/0/1", ifc.err_flag, ifc.UW_ready, ifc.UW_Busy_for_WS);
    end
    n_cmp++; if (st_q.size() != 2) begin n_bad++; $display("FAIL error starts: got %0d want 2", st_q.size()); end
    pulse_finish();
    repeat (20) @(negedge clk);
    n_cmp++; if (st_q.size() != 2 || ifc.err_flag !== 2'b11) begin
      n_bad++; $display("FAIL error stuck: starts %0d want 2, err %b want 11", st_q.size(), ifc.err_flag);
    end
    rst_n = 1'b0; #1;
    n_cmp++; if ({ifc.err_flag, ifc.UW_ready, ifc.UW_Busy_for_WS, ifc.patch_num} !== {2'b00, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL error recover: err=%b ready=%b busy=%b pn=%0d want 00/1/0/0",
                        ifc.err_flag, ifc.UW_ready, ifc.UW_Busy_for_WS, ifc.patch_num);
    end
    @(negedge clk); rst_n = 1'b1;
    err_on = 0;
    mdl_patch = 0;
  endtask

  task automatic test_overrun();
    logic [135:0] e_rd, e_txn; logic [PW-1:0] e_pn; int e_fin;
    bit seen = 0;
    for (int i = 0; i < PTRS; i++) vals[i] = $urandom & 32'h7FFF_FFFF;
    model(e_rd, e_txn, e_pn, e_fin);
    clear_mon();
    load_mem();
    pulse_finish();
    for (int k = 0; k < 50 && !seen; k++) begin @(negedge clk); if (st_q.size() > 0) seen = 1; end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL overrun first start: none within 50 cycles, want 1"); end
    pulse_finish();
    wait_idle("overrun");
    mdl_patch = (mdl_patch + 1) % (2 ** PW);
    n_cmp++; if (ifc.err_flag !== 2'b10) begin n_bad++; $display("FAIL overrun err_flag: got %b want 10", ifc.err_flag); end
    n_cmp++; if (pack4(st_q) !== e_txn || ifc.patch_num !== e_pn) begin
      n_bad++; $display("FAIL overrun txns: got %h want %h, pn %0d want %0d", pack4(st_q), e_txn, ifc.patch_num, e_pn);
    end
    // Reset while the first transaction of the next patch is in WAIT.
    clear_mon();
    load_mem();
    pulse_finish();
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin @(negedge clk); if (st_q.size() > 0) seen = 1; end
    @(posedge clk); #2 rst_n = 1'b0; #1;
    n_cmp++; if ({seen, ifc.UW_Busy_for_WS, ifc.patch_num, ifc.err_flag, ifc.ram_en} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0}) begin
      n_bad++; $display("FAIL reset mid-wait: seen=%b busy=%b pn=%0d err=%b en=%b want 1/0/0/00/0",
                        seen, ifc.UW_Busy_for_WS, ifc.patch_num, ifc.err_flag, ifc.ram_en);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    mdl_patch = 0;
    clear_mon();
    repeat (20) @(negedge clk);
    n_cmp++; if (st_q.size() != 0 || rd_q.size() != 0 || ifc.UW_Busy_for_WS !== 1'b0) begin
      n_bad++; $display("FAIL post-reset quiet: starts %0d reads %0d busy %b want 0/0/0", st_q.size(), rd_q.size(), ifc.UW_Busy_for_WS);
    end
  endtask

  initial begin
    ifc.U_L0_Finish = 1'b0;
    ifc.UW_busy     = 1'b0;
    test_reset();
    test_patch0();
    test_patch1();
    test_unmapped();
    test_random();
    test_txn_error();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/unet_patch_scheduler.md
# unet_patch_scheduler

Sequences flash write-back of U-Net output patches in the Unet-to-DDR wrapper. On each U-Net layer-0 completion it walks that patch's mapping pointers in the base-address BRAM, presents each pointer to the CWBP decode path, and fires one AXI master transaction per mapped pointer. It counts patches and raises the module-finish pulse consumed by the water-S logic. It replaces the free-standing patch counter and the `Transfer_Done`-driven start in the wrapper.

## Interface
- `BRAM_BASE_ADDR`, 32'h4580_0000: byte address of pointer 0 of patch 0.
- `PTRS_PER_PATCH`, 4: mapping pointers per patch (1..256).
- `PATCH_W`, 1: width of `patch_num`; patches per module run = 2**PATCH_W.
- `UNMAPPED_PTR`, 32'hFFFF_FFFF: pointer value meaning "no destination, skip".

Ports:
- `m01_axi_aclk`  in  1  sole clock.
- `m01_axi_aresetn`  in  1  reset, asynchronous assert, active-low.
- `U_L0_Finish`  in  1  single-cycle pulse: patch data ready.
- `UW_busy`  in  1  U-Net still computing; gates `UW_ready`.
- `ram_addr`  out  32  BRAM byte address.
- `ram_en`  out  1  BRAM read enable. Read data is valid one cycle later.
- `ram_rd_data`  in  32  BRAM read data.
- `map_ptr`  out  32  current mapping pointer, to the CWBP decoder.
- `txn_start`  out  1  single-cycle pulse to the M01 AXI master (`INIT_AXI_TXN`).
- `txn_done`  in  1  single-cycle pulse: transaction complete.
- `txn_error`  in  1  qualifies `txn_done`: transaction failed.
- `UW_ready`  out  1  scheduler can accept the next patch.
- `UW_Busy_for_WS`  out  1  scheduler is mid-patch.
- `UW_module_Finish`  out  1  single-cycle pulse: last patch of the run is done.
- `patch_num`  out  PATCH_W  index of the patch being or next to be serviced.
- `err_flag`  out  2  sticky error bits: [0] transaction error, [1] overrun.

## Operation
The state machine has seven states.
- **IDLE**
  - `U_L0_Finish` → RD; `ptr_idx` is set to 0.
- **RD**
  - `ram_en` = 1.
  - `ram_addr` = BRAM_BASE_ADDR + 4*(patch_num*PTRS_PER_PATCH + ptr_idx). Arithmetic is 32-bit and wraps mod 2^32.
  - Next state is CAP.
- **CAP**
  - `ram_rd_data` is registered into `map_ptr`.
  - If the value equals UNMAPPED_PTR → NEXT; otherwise → ISSUE.
- **ISSUE**
  - `txn_start` = 1 for exactly one cycle.
  - Next state is WAIT.
- **WAIT**
  - Holds until `txn_done`.
  - `txn_done` with `txn_error` = 1 → ERR and set `err_flag[0]`.
  - `txn_done` alone → NEXT.
- **NEXT**
  - If `ptr_idx` == PTRS_PER_PATCH-1: the patch is complete and the state returns to IDLE.
    - `patch_num` increments and wraps from 2**PATCH_W-1 to 0.
    - On that wrap, `UW_module_Finish` = 1 in the same cycle.
  - Otherwise `ptr_idx` increments and the state moves to RD.
- **ERR**
  - Terminal state; only reset leaves it.
  - `UW_ready` = 0, `UW_Busy_for_WS` = 1, `txn_start` = 0.

Output rules:
- `UW_ready` = (state == IDLE) & ~`UW_busy`, registered-state combinational.
- `UW_Busy_for_WS` = (state != IDLE).
- `map_ptr` is stable from ISSUE through WAIT. It holds its value in all other states until the next CAP.

Boundary conditions:
- `U_L0_Finish` outside IDLE is ignored for sequencing and sets `err_flag[1]`. The sequence in flight is unaffected.
- `txn_done` outside WAIT is ignored.
- `txn_error` without `txn_done` is ignored.
- If every pointer of a patch is UNMAPPED_PTR, the patch completes with no `txn_start`, and `patch_num` still advances.
- PTRS_PER_PATCH = 1: NEXT always ends the patch.
- Reset is asynchronous and may arrive in any state. All registers clear immediately, and no `txn_start` is emitted after deassertion until a new `U_L0_Finish`.

## Timing
- Reset values:
  - State = IDLE.
  - `ram_addr` = BRAM_BASE_ADDR, `ram_en` = 0.
  - `map_ptr` = 0, `txn_start` = 0.
  - `UW_Busy_for_WS` = 0, `UW_module_Finish` = 0.
  - `patch_num` = 0, `err_flag` = 2'b00.
  - `UW_ready` = ~`UW_busy`.
- Latency from `U_L0_Finish` (cycle 0):
  - cycle 1 → RD (`ram_en` high)
  - cycle 2 → CAP
  - cycle 3 → ISSUE (`txn_start`)
- Per mapped pointer: RD, CAP, ISSUE, ≥1 WAIT, NEXT = 5 cycles minimum. Per unmapped pointer: RD, CAP, NEXT = 3 cycles.
- `txn_done` is sampled starting in the first WAIT cycle, which is the cycle after `txn_start`. It is never accepted in the ISSUE cycle.
- `UW_module_Finish` is high for exactly one cycle: the NEXT cycle ending the last patch. `patch_num` reads 0 from the following cycle.

## Test plan
Defaults apply unless stated. The BRAM model returns data one cycle after `ram_en`. The AXI stub pulses `txn_done` 3 cycles after `txn_start`.

1. **Reset values.** Hold reset with `UW_busy` = 0 → all reset values above hold and `UW_ready` = 1. Release reset with no `U_L0_Finish` → no `ram_en` and no `txn_start` for 20 cycles.
2. **Patch 0.** Pulse `U_L0_Finish`; the BRAM returns 0x0000_1003, 0x0001_2000, 0x0002_0001, 0x0003_0004. Required:
   - reads at 0x4580_0000/04/08/0C;
   - 4 `txn_start` pulses, with `map_ptr` equal to each value during its WAIT;
   - `patch_num` goes 0 → 1; no `UW_module_Finish`;
   - first `txn_start` in cycle 3.
3. **Patch 1.** Second `U_L0_Finish` → reads at 0x4580_0010..1C. A one-cycle `UW_module_Finish` occurs on the last NEXT, and `patch_num` returns to 0.
4. **Unmapped pointer.** Pointer index 2 = 0xFFFF_FFFF → exactly 3 `txn_start` pulses, and the patch still completes.
5. **Transaction error.** `txn_done` + `txn_error` on the 2nd pointer → ERR. Then `err_flag` = 2'b01, `UW_ready` = 0, `UW_Busy_for_WS` = 1, and no further `txn_start`, even with a new `U_L0_Finish`. Applying reset recovers to IDLE with `err_flag` = 0.
6. **Overrun and reset mid-WAIT.** `U_L0_Finish` during WAIT → `err_flag` = 2'b10 and the 4 transactions still complete. A later reset asserted mid-WAIT → the state is IDLE on the next edge and no `txn_start` follows the pending `txn_done`.
